bfp_stage_scaler_ctrl: RTL
==========================

Name: bfp_stage_scaler_ctrl

Overview:
- Block-floating-point scaling controller for the radix-2 FFT core.
- Collects per-sample bit widths from the bit-width detectors during each pass and takes the running maximum.
- At each pass boundary, computes the right-shift the datapath applies on the next pass, then starts that pass.
- Accumulates the total block exponent over the transform and reports it at the end.

Parameters:
- FFT_LENGTH_LOG2, 10, number of butterfly stages N.
- FFT_DW, 16, datapath sample width (signed).
- FFT_BFPDW, 5, width of bit-width and shift values.
- TARGET_BW, FFT_DW-2, largest input magnitude width allowed into a butterfly pass (keeps 1 bit of growth headroom).
- EXP_DW, 8, block exponent width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- run_start  in  1  pulse: begin a transform; the input load pass starts now.
- load_done  in  1  pulse: input load pass finished.
- stage_done  in  1  pulse: current datapath pass finished.
- bw_valid  in  1  bw_in is valid this cycle.
- bw_in  in  FFT_BFPDW  magnitude bit width from the detector.
- stage_go  out  1  pulse: datapath starts pass stage_idx using shift_out.
- stage_idx  out  $clog2(FFT_LENGTH_LOG2+1)  pass index; 0..N-1 are butterfly stages, N is the unload pass.
- shift_out  out  FFT_BFPDW  right-shift for the current pass; held stable between stage_go pulses.
- busy  out  1  high from run_start acceptance until done.
- done  out  1  one-cycle pulse at transform end.
- exponent  out  EXP_DW  total block exponent; valid from done until the next accepted run_start.
- err  out  1  sticky protocol error; cleared only by rst or an accepted run_start.

Behaviour:
- Reset values: all outputs 0; state IDLE; running max 0; exponent accumulator 0.
- States:
  - IDLE: on run_start → LOAD. Clear the running max and accumulator, set busy=1 and err=0. exponent output holds its old value until done.
  - LOAD: bw_valid samples update the running max. On load_done → CLOSE with next index 0.
  - CLOSE (exactly 1 cycle):
    - Compute shift = (max > TARGET_BW) ? max − TARGET_BW : 0.
    - Register shift_out, stage_idx, stage_go=1 in the following cycle.
    - Add shift to the accumulator; clear the running max.
    - → RUN.
  - RUN: bw_valid samples update the running max.
    - On stage_done with stage_idx < N → CLOSE with next index stage_idx+1.
    - On stage_done with stage_idx == N → FIN.
  - FIN (1 cycle): exponent ← accumulator; done=1 and busy=0 in the following cycle; → IDLE.
- Latency:
  - load_done or stage_done sampled at edge k → stage_go high during cycle k+2.
  - Last stage_done at edge k → done high during cycle k+2.
- bw_in handling:
  - Values above FFT_DW are clamped to FFT_DW before the max compare.
  - bw_valid in the same cycle as load_done or stage_done is included in the closing pass.
  - bw_valid during the unload pass (stage_idx == N) is ignored.
  - bw_valid in IDLE, CLOSE or FIN is ignored and sets err.
- Handshake errors:
  - stage_done or load_done in the wrong state is ignored and sets err. This covers load_done in RUN, stage_done in LOAD, and either in IDLE.
  - run_start while busy is ignored and sets err.
- Accumulator: sum of the N+1 computed shifts (passes 0..N). It saturates at 2^EXP_DW−1 and never wraps.
- rst in any state, including mid-pass, returns everything to reset values on the next edge. No stage_go or done is emitted afterwards.

Test Plan:
- Reset: assert rst 3 cycles mid-RUN → all outputs 0 next cycle; a later stage_done produces no stage_go and sets err.
- Full run, FFT_LENGTH_LOG2=3, FFT_DW=16:
  - Stimulus: load max bw 15; stage max bw 14, 16, 13; unload bw ignored.
  - Expect stage_go idx 0,1,2,3 with shift_out 1,0,2,0.
  - Expect done with exponent=3; each stage_go exactly 2 cycles after its done pulse.
- Edge sample: bw_in=15 with bw_valid in the same cycle as stage_done, all earlier samples 10 → next shift_out=1.
- Clamp: bw_in=31 during LOAD (FFT_DW=16) → shift_out=2.
- Protocol: run_start while busy, or load_done during RUN → ignored, err=1, sequence completes unchanged; next accepted run_start clears err.
- Saturation: EXP_DW=2, shifts 2,2,2,0 → exponent=3.

Source files
------------

// File: rtl/bfp_stage_scaler_ctrl.sv
// Block-floating-point scaling controller: tracks max sample bit width per pass and sets the next pass's right-shift.
// Latency: load_done/stage_done at edge k -> stage_go during cycle k+2; last stage_done at edge k -> done during cycle k+2.
// Backpressure: none; pulses that arrive in the wrong state are dropped and raise the sticky err flag.
module bfp_stage_scaler_ctrl #(
    parameter int FFT_LENGTH_LOG2 = 10,
    parameter int FFT_DW          = 16,
    parameter int FFT_BFPDW       = 5,
    parameter int TARGET_BW       = FFT_DW - 2,
    parameter int EXP_DW          = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 run_start,
    input  logic                                 load_done,
    input  logic                                 stage_done,
    input  logic                                 bw_valid,
    input  logic [FFT_BFPDW-1:0]                 bw_in,
    output logic                                 stage_go,
    output logic [$clog2(FFT_LENGTH_LOG2+1)-1:0] stage_idx,
    output logic [FFT_BFPDW-1:0]                 shift_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [EXP_DW-1:0]                    exponent,
    output logic                                 err
);

    localparam int IDXW = $clog2(FFT_LENGTH_LOG2 + 1);
    localparam int SUMW = EXP_DW + FFT_BFPDW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLOSE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [IDXW-1:0]      LAST_IDX  = IDXW'(FFT_LENGTH_LOG2);
    localparam logic [FFT_BFPDW-1:0] BW_CLAMP  = FFT_BFPDW'(FFT_DW);
    localparam logic [FFT_BFPDW-1:0] BW_TARGET = FFT_BFPDW'(TARGET_BW);
    localparam logic [SUMW-1:0]      ACC_MAX   = {{(SUMW-EXP_DW){1'b0}}, {EXP_DW{1'b1}}};

    logic [2:0]           state;
    logic [FFT_BFPDW-1:0] max_bw;
    logic [IDXW-1:0]      next_idx;
    logic [EXP_DW-1:0]    acc;

    logic [FFT_BFPDW-1:0] bw_clamped;
    logic [FFT_BFPDW-1:0] shift_calc;
    logic [SUMW-1:0]      acc_sum;
    logic [EXP_DW-1:0]    acc_next;
    logic                 sample_ok;
    logic                 start_ok;
    logic                 proto_err;

    // Clamp, shift, saturating accumulate and protocol-error decode.
    always_comb begin
        bw_clamped = (bw_in > BW_CLAMP) ? BW_CLAMP : bw_in;
        shift_calc = (max_bw > BW_TARGET) ? (max_bw - BW_TARGET) : '0;
        acc_sum    = SUMW'(acc) + SUMW'(shift_calc);
        acc_next   = (acc_sum > ACC_MAX) ? {EXP_DW{1'b1}} : acc_sum[EXP_DW-1:0];
        // The unload pass (index N) produces no butterfly input, so its widths are not collected.
        sample_ok  = (state == S_LOAD) || ((state == S_RUN) && (stage_idx != LAST_IDX));
        start_ok   = run_start && (state == S_IDLE);
        proto_err  = (bw_valid && ((state == S_IDLE) || (state == S_CLOSE) || (state == S_FIN)))
                   | (load_done  && (state != S_LOAD))
                   | (stage_done && (state != S_RUN))
                   | (run_start  && (state != S_IDLE));
    end

    // Pass sequencing, running max, exponent accumulation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            max_bw    <= '0;
            next_idx  <= '0;
            acc       <= '0;
            stage_go  <= 1'b0;
            stage_idx <= '0;
            shift_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exponent  <= '0;
            err       <= 1'b0;
        end else begin
            stage_go <= 1'b0;
            done     <= 1'b0;
            err      <= (start_ok ? 1'b0 : err) | proto_err;

            // A sample coinciding with the closing pulse still lands here and is seen by CLOSE.
            if (bw_valid && sample_ok && (bw_clamped > max_bw)) begin
                max_bw <= bw_clamped;
            end

            case (state)
                S_IDLE: begin
                    if (run_start) begin
                        state    <= S_LOAD;
                        max_bw   <= '0;
                        acc      <= '0;
                        next_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        next_idx <= '0;
                        state    <= S_CLOSE;
                    end
                end
                S_CLOSE: begin
                    shift_out <= shift_calc;
                    stage_idx <= next_idx;
                    stage_go  <= 1'b1;
                    acc       <= acc_next;
                    max_bw    <= '0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (stage_done) begin
                        if (stage_idx == LAST_IDX) begin
                            state <= S_FIN;
                        end else begin
                            next_idx <= stage_idx + 1'b1;
                            state    <= S_CLOSE;
                        end
                    end
                end
                S_FIN: begin
                    exponent <= acc;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
